// File: rtl/popcnt_arbiter.sv
// rtl/popcnt_arbiter.sv - round-robin arbiter feeding a chunked popcount engine
// Optional early exit on all-zero upper chunks: POPCNT_ARBITER_EARLY_EXIT_EN
module popcnt_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 64,
    parameter int CHUNK_WIDTH = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                req_valid_i,
    output logic [NUM_REQ-1:0]                req_ready_o,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_data_i,
    output logic                              resp_valid_o,
    input  logic                              resp_ready_i,
    output logic [$clog2(DATA_WIDTH+1)-1:0]   resp_cnt_o,
    output logic [$clog2(NUM_REQ)-1:0]        resp_id_o,
    output logic                              busy_o
);

    localparam int NCHUNK = DATA_WIDTH / CHUNK_WIDTH;
    localparam int CNT_W  = $clog2(DATA_WIDTH + 1);
    localparam int ID_W   = $clog2(NUM_REQ);
    localparam int SUM_W  = ID_W + 1;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ID_W-1:0]       ptr_q, ptr_d;
    logic [ID_W-1:0]       id_q, id_d;
    logic [CNT_W-1:0]      acc_q, acc_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  resp_valid_q, resp_valid_d;
    logic                  busy_q, busy_d;

    logic                  grant_found;
    logic [ID_W-1:0]       grant_idx;
    logic [SUM_W-1:0]      cand_sum;
    logic                  accept;
    logic [CHUNK_WIDTH-1:0] chunk;
    logic [CNT_W-1:0]      chunk_cnt;
    logic                  last_chunk;
    logic                  run_done;

    // Search starts at ptr and wraps, so the first valid found is the round-robin winner
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_sum    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_sum = {1'b0, ptr_q} + SUM_W'(i);
            if (cand_sum >= SUM_W'(NUM_REQ)) begin
                cand_sum = cand_sum - SUM_W'(NUM_REQ);
            end
            if (!grant_found && req_valid_i[cand_sum[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand_sum[ID_W-1:0];
            end
        end
    end

    assign accept      = (state_q == S_IDLE) && grant_found && !rst;
    assign req_ready_o = accept ? (NUM_REQ'(1) << grant_idx) : '0;

    always_comb begin
        chunk     = data_q[int'(idx_q)*CHUNK_WIDTH +: CHUNK_WIDTH];
        chunk_cnt = '0;
        for (int b = 0; b < CHUNK_WIDTH; b++) begin
            chunk_cnt = chunk_cnt + CNT_W'(chunk[b]);
        end
    end

    assign last_chunk = (int'(idx_q) == NCHUNK - 1);

`ifdef POPCNT_ARBITER_EARLY_EXIT_EN
    logic upper_zero;

    always_comb begin
        upper_zero = 1'b1;
        for (int j = 0; j < NCHUNK; j++) begin
            if ((j > int'(idx_q)) && (data_q[j*CHUNK_WIDTH +: CHUNK_WIDTH] != '0)) begin
                upper_zero = 1'b0;
            end
        end
    end

    assign run_done = last_chunk || upper_zero;
`else
    assign run_done = last_chunk;
`endif

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        id_d         = id_q;
        acc_d        = acc_q;
        idx_d        = idx_q;
        data_d       = data_q;
        resp_valid_d = resp_valid_q;
        busy_d       = busy_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    data_d  = req_data_i[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
                    id_d    = grant_idx;
                    acc_d   = '0;
                    idx_d   = '0;
                    ptr_d   = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
                    state_d = S_RUN;
                    busy_d  = 1'b1;
                end
            end
            S_RUN: begin
                acc_d = acc_q + chunk_cnt;
                idx_d = idx_q + 1'b1;
                if (run_done) begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                end
            end
            S_RESP: begin
                if (resp_ready_i) begin
                    state_d      = S_IDLE;
                    resp_valid_d = 1'b0;
                    busy_d       = 1'b0;
                end
            end
            default: begin
                state_d      = S_IDLE;
                resp_valid_d = 1'b0;
                busy_d       = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            id_q         <= '0;
            acc_q        <= '0;
            idx_q        <= '0;
            data_q       <= '0;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            id_q         <= id_d;
            acc_q        <= acc_d;
            idx_q        <= idx_d;
            data_q       <= data_d;
            resp_valid_q <= resp_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign resp_valid_o = resp_valid_q;
    assign busy_o       = busy_q;
    assign resp_cnt_o   = acc_q;
    assign resp_id_o    = id_q;

endmodule

// File: tb/tb_popcnt_arbiter.sv
// tb/tb_popcnt_arbiter.sv - directed and randomized checks of popcnt_arbiter against a round-robin/popcount model
module tb_popcnt_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid_i;
    logic [3:0]   req_ready_o;
    logic [255:0] req_data_i;
    logic         resp_valid_o;
    logic         resp_ready_i;
    logic [6:0]   resp_cnt_o;
    logic [1:0]   resp_id_o;
    logic         busy_o;

    popcnt_arbiter #(.NUM_REQ(4), .DATA_WIDTH(64), .CHUNK_WIDTH(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_data_i   (req_data_i),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .resp_cnt_o   (resp_cnt_o),
        .resp_id_o    (resp_id_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          mptr    = 0;
    logic [63:0] rdata [4];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_data();
        for (int i = 0; i < 4; i++) req_data_i[i*64 +: 64] = rdata[i];
    endtask

    function automatic int model_grant(input logic [3:0] vm);
        for (int i = 0; i < 4; i++) begin
            if (vm[(mptr + i) % 4]) return (mptr + i) % 4;
        end
        return -1;
    endfunction

    // Cycles from the accept cycle to the first cycle with a valid response
    function automatic int model_lat(input logic [63:0] d);
`ifdef POPCNT_ARBITER_EARLY_EXIT_EN
        int hi = 0;
        for (int k = 0; k < 4; k++) if (d[k*16 +: 16] != 16'h0) hi = k;
        return hi + 2;
`else
        return 5;
`endif
    endfunction

    function automatic logic [63:0] rand_data();
        logic [63:0] d = {$urandom(), $urandom()};
        for (int k = 0; k < 4; k++) if ($urandom_range(0, 2) == 0) d[k*16 +: 16] = 16'h0;
        return d;
    endfunction

    task automatic txn(input logic [3:0] vm, input bit keep_valid, input int stall);
        int g, lat;
        logic [63:0] d;
        g = model_grant(vm);
        d = rdata[g];
        req_valid_i = vm;
        drive_data();
        #1;
        chk("grant_onehot", req_ready_o, 4'b0001 << g);
        chk("busy_idle", busy_o, 1'b0);
        tick();
        mptr = (g + 1) % 4;
        if (!keep_valid) req_valid_i = 4'h0;
        rdata[g] = ~d;
        drive_data();
        lat = 1;
        while (!resp_valid_o && lat < 40) begin
            chk("ready_run", req_ready_o, 4'h0);
            chk("busy_run", busy_o, 1'b1);
            tick();
            lat++;
        end
        chk("latency", lat, model_lat(d));
        chk("resp_valid", resp_valid_o, 1'b1);
        chk("resp_cnt", resp_cnt_o, $countones(d));
        chk("resp_id", resp_id_o, g);
        for (int s = 0; s < stall; s++) begin
            resp_ready_i = 1'b0;
            tick();
            chk("stall_valid", resp_valid_o, 1'b1);
            chk("stall_cnt", resp_cnt_o, $countones(d));
            chk("stall_id", resp_id_o, g);
            chk("stall_ready", req_ready_o, 4'h0);
        end
        resp_ready_i = 1'b1;
        tick();
        resp_ready_i = 1'b0;
        chk("post_hs_valid", resp_valid_o, 1'b0);
        chk("post_hs_busy", busy_o, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] vm;
        rst          = 1'b1;
        req_valid_i  = 4'hF;
        resp_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) rdata[i] = rand_data();
        drive_data();
        tick();
        chk("reset_ready", req_ready_o, 4'h0);
        tick();
        chk("reset_busy", busy_o, 1'b0);
        chk("reset_valid", resp_valid_o, 1'b0);
        req_valid_i = 4'h0;
        rst = 1'b0;
        #1;
        chk("no_req_ready", req_ready_o, 4'h0);

        // All four held valid: round robin 0,1,2,3,0
        for (int n = 0; n < 5; n++) txn(4'hF, 1'b1, 0);
        req_valid_i = 4'h0;

        rdata[2] = 64'hFFFF_FFFF_FFFF_FFFF;
        txn(4'b0100, 1'b0, 0);

        rdata[1] = rand_data();
        txn(4'b0010, 1'b0, 10);

        rdata[3] = 64'h8000_0000_0000_0001;
        txn(4'b1000, 1'b0, 0);
        rdata[0] = 64'h0000_0000_0000_00F0;
        txn(4'b0001, 1'b0, 0);
        rdata[2] = 64'h0;
        txn(4'b0100, 1'b0, 0);

        for (int n = 0; n < 25; n++) begin
            for (int i = 0; i < 4; i++) rdata[i] = rand_data();
            vm = 4'($urandom_range(1, 15));
            txn(vm, $urandom_range(0, 1) == 1, $urandom_range(0, 2));
        end
        req_valid_i = 4'h0;

        // Reset during RUN, with ptr pointing away from 0 beforehand
        rdata[0] = rand_data();
        req_valid_i = 4'b0001;
        drive_data();
        tick();
        req_valid_i = 4'h0;
        tick();
        rst = 1'b1;
        req_valid_i = 4'hF;
        #1;
        chk("midrun_rst_ready", req_ready_o, 4'h0);
        tick();
        rst = 1'b0;
        req_valid_i = 4'h0;
        mptr = 0;
        #1;
        chk("midrun_busy", busy_o, 1'b0);
        chk("midrun_valid", resp_valid_o, 1'b0);
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("midrun_no_resp", resp_valid_o, 1'b0);
        end
        rdata[0] = rand_data();
        rdata[1] = rand_data();
        txn(4'b0011, 1'b0, 0);
        rdata[1] = 64'h0000_0000_0000_0F0F;
        txn(4'b0010, 1'b0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
